ctrl_sequencer: RTL and testbench

Hardwired control unit for the 32-bit bus datapath: a T-state sequencer that fetches an instruction through PC/MAR/MDR into IR, decodes it, and drives the one-hot bus-select word into the 32:5 bus encoder plus every register-load strobe, ALU op and memory handshake. It is the only master of the shared bus; all transfers are one bus source per cycle.

---
 rtl/ctrl_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: hardwired T-state control unit driving bus select, load strobes, ALU op and memory handshake
module ctrl_sequencer #(
    parameter int MEM_WAIT_MAX = 0
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        mem_done,
    output logic [31:0] bus_sel,
    output logic [15:0] reg_in,
    output logic        pc_in,
    output logic        ir_in,
    output logic        y_in,
    output logic        z_in,
    output logic        mar_in,
    output logic        hi_in,
    output logic        lo_in,
    output logic        mdr_in,
    output logic        mdr_read,
    output logic [3:0]  alu_op,
    output logic        mem_read,
    output logic        mem_write,
    output logic        run,
    output logic [1:0]  fault,
    output logic [3:0]  tstate
);
    localparam int WW = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
    localparam logic [WW-1:0] LAST = WW'((MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0);
    localparam int B_HI  = 16;
    localparam int B_LO  = 17;
    localparam int B_ZHI = 18;
    localparam int B_ZLO = 19;
    localparam int B_PC  = 20;
    localparam int B_MDR = 21;
    localparam int B_C   = 23;
    typedef enum logic [3:0] {
        S_T0 = 4'd0, S_T1 = 4'd1, S_T2 = 4'd2, S_T3 = 4'd3,
        S_T4 = 4'd4, S_T5 = 4'd5, S_T6 = 4'd6, S_T7 = 4'd7,
        S_HALT = 4'd8, S_RST = 4'hF
    } state_t;
    state_t        r_state;
    state_t        w_nxt;
    logic [1:0]    r_fault;
    logic [WW-1:0] r_wait;
    logic [4:0]    w_op;
    logic [3:0]    w_ra;
    logic [3:0]    w_rb;
    logic [3:0]    w_rc;
    logic [15:0]   w_ra1h;
    logic          w_ld;
    logic          w_st;
    logic          w_addi;
    logic          w_alu;
    logic          w_mul;
    logic          w_mfhi;
    logic          w_mflo;
    logic          w_nop;
    logic          w_ill;
    logic          w_mem;
    logic          w_tmo;
    logic          w_unused;
    assign w_op     = ir[31:27];
    assign w_ra     = ir[26:23];
    assign w_rb     = ir[22:19];
    assign w_rc     = ir[18:15];
    assign w_unused = ^ir[14:0];
    assign w_ra1h   = 16'd1 << w_ra;
    assign w_ld     = w_op == 5'd0;
    assign w_st     = w_op == 5'd1;
    assign w_addi   = w_op == 5'd2;
    assign w_alu    = (w_op >= 5'd3) && (w_op <= 5'd6);
    assign w_mul    = w_op == 5'd7;
    assign w_mfhi   = w_op == 5'd8;
    assign w_mflo   = w_op == 5'd9;
    assign w_nop    = w_op == 5'd10;
    assign w_ill    = w_op > 5'd11;
    assign w_mem    = (r_state == S_T1) || (r_state == S_T6 && w_ld) || (r_state == S_T7 && w_st);
    assign w_tmo    = (MEM_WAIT_MAX > 0) && w_mem && !mem_done && (r_wait == LAST);
    assign run      = (r_state != S_RST) && (r_state != S_HALT);
    assign fault    = r_fault;
    assign tstate   = r_state;
    // state register, sticky fault and memory wait counter (cleared on entry to every memory state)
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state <= S_RST;
            r_fault <= 2'd0;
            r_wait  <= '0;
        end else begin
            r_state <= w_nxt;
            r_wait  <= (w_mem && w_nxt == r_state) ? r_wait + WW'(1) : '0;
            if (w_tmo) r_fault <= 2'd2;
            else if (r_state == S_T3 && w_ill) r_fault <= 2'd1;
        end
    end
    // next state and strobes per T-state; memory states also react to mem_done in the completing cycle
    always_comb begin
        w_nxt     = r_state;
        bus_sel   = '0;
        reg_in    = '0;
        pc_in     = 1'b0;
        ir_in     = 1'b0;
        y_in      = 1'b0;
        z_in      = 1'b0;
        mar_in    = 1'b0;
        hi_in     = 1'b0;
        lo_in     = 1'b0;
        mdr_in    = 1'b0;
        mdr_read  = 1'b0;
        alu_op    = 4'd0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        case (r_state)
            S_RST: w_nxt = S_T0;
            S_T0: begin
                bus_sel = 32'd1 << B_PC;
                mar_in  = 1'b1;
                alu_op  = 4'd5;
                z_in    = 1'b1;
                w_nxt   = S_T1;
            end
            S_T1: begin
                mem_read = 1'b1;
                mdr_read = 1'b1;
                mdr_in   = mem_done;
                pc_in    = mem_done;
                bus_sel  = mem_done ? 32'd1 << B_ZLO : '0;
                w_nxt    = mem_done ? S_T2 : (w_tmo ? S_HALT : S_T1);
            end
            S_T2: begin
                bus_sel = 32'd1 << B_MDR;
                ir_in   = 1'b1;
                w_nxt   = S_T3;
            end
            S_T3: begin
                if (w_ld || w_st || w_addi || w_alu || w_mul) begin
                    bus_sel = 32'd1 << (w_mul ? w_ra : w_rb);
                    y_in    = 1'b1;
                    w_nxt   = S_T4;
                end else if (w_mfhi || w_mflo) begin
                    bus_sel = 32'd1 << (w_mfhi ? B_HI : B_LO);
                    reg_in  = w_ra1h;
                    w_nxt   = S_T0;
                end else begin
                    w_nxt = w_nop ? S_T0 : S_HALT;
                end
            end
            S_T4: begin
                bus_sel = w_mul ? 32'd1 << w_rb : (w_alu ? 32'd1 << w_rc : 32'd1 << B_C);
                alu_op  = w_mul ? 4'd4 : (w_alu ? w_op[3:0] - 4'd3 : 4'd0);
                z_in    = 1'b1;
                w_nxt   = S_T5;
            end
            S_T5: begin
                bus_sel = 32'd1 << B_ZLO;
                lo_in   = w_mul;
                mar_in  = w_ld || w_st;
                reg_in  = (w_mul || w_ld || w_st) ? '0 : w_ra1h;
                w_nxt   = (w_mul || w_ld || w_st) ? S_T6 : S_T0;
            end
            S_T6: begin
                if (w_mul) begin
                    bus_sel = 32'd1 << B_ZHI;
                    hi_in   = 1'b1;
                    w_nxt   = S_T0;
                end else if (w_ld) begin
                    mem_read = 1'b1;
                    mdr_read = 1'b1;
                    mdr_in   = mem_done;
                    w_nxt    = mem_done ? S_T7 : (w_tmo ? S_HALT : S_T6);
                end else begin
                    bus_sel = 32'd1 << w_ra;
                    mdr_in  = 1'b1;
                    w_nxt   = S_T7;
                end
            end
            S_T7: begin
                if (w_ld) begin
                    bus_sel = 32'd1 << B_MDR;
                    reg_in  = w_ra1h;
                    w_nxt   = S_T0;
                end else begin
                    mem_write = 1'b1;
                    w_nxt     = mem_done ? S_T0 : (w_tmo ? S_HALT : S_T7);
                end
            end
            default: w_nxt = S_HALT;
        endcase
    end
endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: directed instruction stream checked cycle by cycle against a micro-step model
module tb_ctrl_sequencer;
    localparam int MAXW = 4;
    localparam logic [7:0] L_PC  = 8'h80;
    localparam logic [7:0] L_IR  = 8'h40;
    localparam logic [7:0] L_Y   = 8'h20;
    localparam logic [7:0] L_Z   = 8'h10;
    localparam logic [7:0] L_MAR = 8'h08;
    localparam logic [7:0] L_HI  = 8'h04;
    localparam logic [7:0] L_LO  = 8'h02;
    localparam logic [7:0] L_MDR = 8'h01;
    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        mem_done = 1'b0;
    logic [31:0] ir = '0;
    logic [31:0] bus_sel;
    logic [15:0] reg_in;
    logic        pc_in, ir_in, y_in, z_in, mar_in, hi_in, lo_in, mdr_in, mdr_read;
    logic [3:0]  alu_op;
    logic        mem_read, mem_write, run;
    logic [1:0]  fault;
    logic [3:0]  tstate;
    ctrl_sequencer #(.MEM_WAIT_MAX(MAXW)) dut (
        .clk(clk), .clr(clr), .ir(ir), .mem_done(mem_done),
        .bus_sel(bus_sel), .reg_in(reg_in),
        .pc_in(pc_in), .ir_in(ir_in), .y_in(y_in), .z_in(z_in),
        .mar_in(mar_in), .hi_in(hi_in), .lo_in(lo_in), .mdr_in(mdr_in),
        .mdr_read(mdr_read), .alu_op(alu_op),
        .mem_read(mem_read), .mem_write(mem_write),
        .run(run), .fault(fault), .tstate(tstate)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic        clr;
        logic        done;
        logic [31:0] ir;
        logic [69:0] o;
        int          tag;
    } rec_t;
    rec_t        q[$];
    rec_t        cur;
    logic        valid = 1'b0;
    int          cur_i = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [1:0]  m_fault = 2'd0;
    logic        m_noise = 1'b0;
    logic [31:0] m_ir = '0;
    logic [69:0] act;
    logic [31:0] lb;
    logic [15:0] lr;
    logic        lx;
    assign act = {bus_sel, reg_in, pc_in, ir_in, y_in, z_in, mar_in, hi_in, lo_in, mdr_in,
                  mdr_read, alu_op, mem_read, mem_write, run, fault, tstate};
    // one expected cycle: tstate, bus source bit (-1 none), reg loads, other loads, mem handshake
    task automatic push(input int ts, input int bit_i, input logic [15:0] rin, input logic [7:0] ld,
                        input logic mrd, input logic [3:0] alu, input logic mr, input logic mw, input logic done);
        rec_t r;
        logic [31:0] b;
        b = (bit_i < 0) ? 32'h0 : (32'h1 << bit_i);
        r.clr  = 1'b1;
        r.done = done;
        r.ir   = m_ir;
        r.tag  = 0;
        r.o    = {b, rin, ld, mrd, alu, mr, mw, ts < 8, m_fault, 4'(ts)};
        q.push_back(r);
    endtask
    task automatic plain(input int ts, input int bit_i, input logic [15:0] rin, input logic [7:0] ld, input logic [3:0] alu);
        push(ts, bit_i, rin, ld, 1'b0, alu, 1'b0, 1'b0, m_noise);
    endtask
    task automatic hcyc(input int n);
        for (int k = 0; k < n; k++) push(8, -1, '0, '0, 1'b0, 4'd0, 1'b0, 1'b0, m_noise);
    endtask
    // memory access with w wait states; w >= MAXW means the request times out
    task automatic mem(input int ts, input logic wr, input int w, input int dbit, input logic [7:0] dld, output logic to);
        int n;
        n  = (w >= MAXW) ? MAXW : w;
        for (int k = 0; k < n; k++) push(ts, -1, '0, '0, !wr, 4'd0, !wr, wr, 1'b0);
        to = (w >= MAXW);
        if (to) m_fault = 2'd2;
        else push(ts, dbit, '0, dld, !wr, 4'd0, !wr, wr, 1'b1);
    endtask
    task automatic instr(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc,
                         input int w1, input int w2);
        logic to;
        m_ir = {op, ra, rb, rc, 15'h0};
        plain(0, 20, '0, L_MAR | L_Z, 4'd5);
        mem(1, 1'b0, w1, 19, L_PC | L_MDR, to);
        if (to) begin
            hcyc(3);
            return;
        end
        plain(2, 21, '0, L_IR, 4'd0);
        if (op == 5'd2 || (op >= 5'd3 && op <= 5'd6)) begin
            plain(3, int'(rb), '0, L_Y, 4'd0);
            plain(4, (op == 5'd2) ? 23 : int'(rc), '0, L_Z, (op == 5'd2) ? 4'd0 : 4'(op - 5'd3));
            plain(5, 19, 16'd1 << ra, '0, 4'd0);
        end else if (op <= 5'd1) begin
            plain(3, int'(rb), '0, L_Y, 4'd0);
            plain(4, 23, '0, L_Z, 4'd0);
            plain(5, 19, '0, L_MAR, 4'd0);
            if (op == 5'd0) begin
                mem(6, 1'b0, w2, -1, L_MDR, to);
                if (to) hcyc(3);
                else plain(7, 21, 16'd1 << ra, '0, 4'd0);
            end else begin
                plain(6, int'(ra), '0, L_MDR, 4'd0);
                mem(7, 1'b1, w2, -1, '0, to);
                if (to) hcyc(3);
            end
        end else if (op == 5'd7) begin
            plain(3, int'(ra), '0, L_Y, 4'd0);
            plain(4, int'(rb), '0, L_Z, 4'd4);
            plain(5, 19, '0, L_LO, 4'd0);
            plain(6, 18, '0, L_HI, 4'd0);
        end else if (op == 5'd8 || op == 5'd9) begin
            plain(3, (op == 5'd8) ? 16 : 17, 16'd1 << ra, '0, 4'd0);
        end else if (op == 5'd10) begin
            plain(3, -1, '0, '0, 4'd0);
        end else begin
            plain(3, -1, '0, '0, 4'd0);
            if (op != 5'd11) m_fault = 2'd1;
            hcyc(3);
        end
    endtask
    task automatic rrec(input logic c);
        push(15, -1, '0, '0, 1'b0, 4'd0, 1'b0, 1'b0, m_noise);
        q[q.size()-1].clr = c;
    endtask
    // cut the stream after n cycles, drive clr low in the last kept cycle and two RST cycles
    task automatic rst(input int n);
        while (q.size() > n) void'(q.pop_back());
        q[q.size()-1].clr = 1'b0;
        m_fault = 2'd0;
        rrec(1'b0);
        rrec(1'b0);
        rrec(1'b1);
    endtask
    // stimulus: build the expected stream, then play it one record per clock
    initial begin
        int b;
        rrec(1'b0);
        q[0].tag = 13;
        rrec(1'b1);
        b = q.size(); instr(5'd3, 4'd3, 4'd1, 4'd2, 0, 0);
        q[b+3].tag = 2; q[b+4].tag = 3; q[b+5].tag = 4;
        m_noise = 1'b1;
        b = q.size(); instr(5'd4, 4'd6, 4'd4, 4'd5, 2, 0);
        q[b].tag = 5;
        m_noise = 1'b0;
        instr(5'd5, 4'd1, 4'd2, 4'd3, 1, 0);
        instr(5'd6, 4'd15, 4'd14, 4'd13, 0, 0);
        instr(5'd2, 4'd2, 4'd3, 4'd0, 0, 0);
        b = q.size(); instr(5'd0, 4'd5, 4'd2, 4'd0, 0, 3);
        q[b+6].tag = 8; q[b+9].tag = 7; q[b+10].tag = 6;
        b = q.size(); instr(5'd1, 4'd7, 4'd1, 4'd0, 0, 2);
        q[b+6].tag = 9;
        b = q.size(); instr(5'd7, 4'd1, 4'd2, 4'd0, 0, 0);
        q[b+5].tag = 14; q[b+6].tag = 15;
        b = q.size(); instr(5'd8, 4'd4, 4'd0, 4'd0, 0, 0);
        q[b+3].tag = 10;
        instr(5'd9, 4'd9, 4'd0, 4'd0, 0, 0);
        instr(5'd10, 4'd0, 4'd0, 4'd0, 0, 0);
        b = q.size(); instr(5'd3, 4'd2, 4'd3, 4'd4, 0, 0);
        rst(b + 5);
        b = q.size(); instr(5'd6, 4'd8, 4'd9, 4'd10, 0, 0);
        q[b].tag = 1;
        b = q.size(); instr(5'd0, 4'd1, 4'd2, 4'd0, 0, 3);
        rst(b + 8);
        q[b+8].tag = 16;
        instr(5'd10, 4'd0, 4'd0, 4'd0, 0, 0);
        instr(5'd11, 4'd0, 4'd0, 4'd0, 0, 0);
        rst(q.size());
        b = q.size(); instr(5'd31, 4'd0, 4'd0, 4'd0, 0, 0);
        q[b+4].tag = 11;
        rst(q.size());
        b = q.size(); instr(5'd0, 4'd1, 4'd1, 4'd0, 0, 9);
        q[b+10].tag = 12;
        rst(q.size());
        instr(5'd10, 4'd0, 4'd0, 4'd0, 6, 0);
        rst(q.size());
        instr(5'd3, 4'd1, 4'd1, 4'd1, 0, 0);
        repeat (2) @(posedge clk);
        foreach (q[i]) begin
            @(posedge clk);
            #1;
            clr      = q[i].clr;
            mem_done = q[i].done;
            ir       = q[i].ir;
            cur      = q[i];
            cur_i    = i;
            valid    = 1'b1;
        end
        @(posedge clk);
        #1 valid = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
    // compare: full output word every cycle, plus literal spot checks on tagged cycles
    always @(negedge clk) begin
        if (valid) begin
            n_cmp++;
            if (act !== cur.o) begin
                n_bad++;
                $display("FAIL cycle %0d outputs: got %h required %h", cur_i, act, cur.o);
            end
            if (cur.tag != 0) begin
                lb = '0;
                lr = '0;
                lx = 1'b1;
                case (cur.tag)
                    1:  begin lb = 32'h0010_0000; lx = mar_in && z_in && alu_op == 4'd5; end
                    2:  begin lb = 32'h0000_0002; lx = y_in; end
                    3:  begin lb = 32'h0000_0004; lx = alu_op == 4'd0 && z_in; end
                    4:  begin lb = 32'h0008_0000; lr = 16'h0008; end
                    5:  begin lb = 32'h0010_0000; lx = tstate == 4'd0; end
                    6:  begin lb = 32'h0020_0000; lr = 16'h0020; end
                    7:  lx = mem_read && mdr_in;
                    8:  lx = mem_read && !mdr_in;
                    9:  begin lb = 32'h0000_0080; lx = !mdr_read && mdr_in; end
                    10: begin lb = 32'h0001_0000; lr = 16'h0010; end
                    11: lx = fault == 2'd1 && !run;
                    12: lx = fault == 2'd2 && !run;
                    13: lx = tstate == 4'hF && !run && !mem_read && !z_in;
                    14: begin lb = 32'h0008_0000; lx = lo_in; end
                    15: begin lb = 32'h0004_0000; lx = hi_in; end
                    16: lx = !mem_read && tstate == 4'hF;
                    default: lx = 1'b0;
                endcase
                n_cmp++;
                if (bus_sel !== lb || reg_in !== lr || lx !== 1'b1) begin
                    n_bad++;
                    $display("FAIL literal%0d cycle %0d: got bus_sel=%h reg_in=%h side=%b tstate=%h fault=%0d, required bus_sel=%h reg_in=%h side=1",
                             cur.tag, cur_i, bus_sel, reg_in, lx, tstate, fault, lb, lr);
                end
            end
        end
    end
endmodule
